// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
// Holds the PC, honours hazard-unit hold requests and ID redirects, and counts stalls/flushes.
module fetch_ifid_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pc_write,
   input  logic             ifid_write,
   input  logic             redirect,
   input  logic [31:0]      redirect_target,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      imem_addr,
   output logic [31:0]      pc,
   output logic [31:0]      ifid_instr,
   output logic [31:0]      ifid_pc4,
   output logic             ifid_valid,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   logic [31:0]      pcPlus4;
   logic [31:0]      alignedTarget;
   logic             stallSat;
   logic             flushSat;
   logic [CNT_W-1:0] cntOne;

   assign imem_addr     = pc;
   assign pcPlus4       = pc + 32'd4;
   assign alignedTarget = {redirect_target[31:2], 2'b00};
   assign stallSat      = &stall_count;
   assign flushSat      = &flush_count;
   assign cntOne        = CNT_W'(1);

   // A stalled redirect is deliberately dropped: ID re-asserts it once operands resolve.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         ifid_instr  <= NOP_INSTR;
         ifid_pc4    <= 32'd0;
         ifid_valid  <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (!pc_write) begin
            if (ifid_write) begin
               ifid_instr <= NOP_INSTR;
               ifid_pc4   <= 32'd0;
               ifid_valid <= 1'b0;
            end
         end else if (redirect) begin
            pc         <= alignedTarget;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
            if (!flushSat) begin
               flush_count <= flush_count + cntOne;
            end
         end else if (!imem_ready) begin
            if (ifid_write) begin
               ifid_instr <= NOP_INSTR;
               ifid_pc4   <= 32'd0;
               ifid_valid <= 1'b0;
            end
         end else begin
            pc <= pcPlus4;
            if (ifid_write) begin
               ifid_instr <= imem_rdata;
               ifid_pc4   <= pcPlus4;
               ifid_valid <= 1'b1;
            end
         end

         if (!pc_write && !stallSat) begin
            stall_count <= stall_count + cntOne;
         end
      end
   end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed self-checking bench for fetch_ifid_stage; a second narrow-counter instance
// exercises counter saturation under the same stimulus.
module tb_fetch_ifid_stage;

   logic        clk;
   logic        reset;
   logic        pcWrite;
   logic        ifidWrite;
   logic        redirect;
   logic [31:0] redirectTarget;
   logic        imemReady;
   logic [31:0] imemRdata;
   logic [31:0] imemAddr;
   logic [31:0] pc;
   logic [31:0] ifidInstr;
   logic [31:0] ifidPc4;
   logic        ifidValid;
   logic [31:0] stallCount;
   logic [31:0] flushCount;

   logic [31:0] smallAddr;
   logic [31:0] smallPc;
   logic [31:0] smallInstr;
   logic [31:0] smallPc4;
   logic        smallValid;
   logic [1:0]  smallStall;
   logic [1:0]  smallFlush;

   int checks;
   int failures;

   fetch_ifid_stage dut (
      .clk(clk), .reset(reset), .pc_write(pcWrite), .ifid_write(ifidWrite),
      .redirect(redirect), .redirect_target(redirectTarget),
      .imem_ready(imemReady), .imem_rdata(imemRdata), .imem_addr(imemAddr),
      .pc(pc), .ifid_instr(ifidInstr), .ifid_pc4(ifidPc4), .ifid_valid(ifidValid),
      .stall_count(stallCount), .flush_count(flushCount)
   );

   fetch_ifid_stage #(.CNT_W(2)) dutSmall (
      .clk(clk), .reset(reset), .pc_write(pcWrite), .ifid_write(ifidWrite),
      .redirect(redirect), .redirect_target(redirectTarget),
      .imem_ready(imemReady), .imem_rdata(imemRdata), .imem_addr(smallAddr),
      .pc(smallPc), .ifid_instr(smallInstr), .ifid_pc4(smallPc4), .ifid_valid(smallValid),
      .stall_count(smallStall), .flush_count(smallFlush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pw, input logic iw, input logic rd, input logic [31:0] tgt,
                        input logic rdy, input logic [31:0] data);
      pcWrite        = pw;
      ifidWrite      = iw;
      redirect       = rd;
      redirectTarget = tgt;
      imemReady      = rdy;
      imemRdata      = data;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      cycle();
      cycle();
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", pc, 32'h0); end
      checks++; if (imemAddr !== 32'h0) begin failures++; $display("FAIL reset_addr actual=%h expected=%h", imemAddr, 32'h0); end
      checks++; if (ifidValid !== 1'b0 || ifidInstr !== 32'h0 || ifidPc4 !== 32'h0) begin failures++; $display("FAIL reset_ifid actual=%b/%h/%h expected=0/0/0", ifidValid, ifidInstr, ifidPc4); end
      checks++; if (stallCount !== 32'd0 || flushCount !== 32'd0) begin failures++; $display("FAIL reset_counts actual=%0d/%0d expected=0/0", stallCount, flushCount); end
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      logic [31:0] words [4];
      words[0] = 32'hAAAA_0001;
      words[1] = 32'hBBBB_0002;
      words[2] = 32'hCCCC_0003;
      words[3] = 32'hDDDD_0004;
      for (int i = 0; i < 4; i++) begin
         checks++; if (imemAddr !== 32'(i * 4)) begin failures++; $display("FAIL seq_addr%0d actual=%h expected=%h", i, imemAddr, 32'(i * 4)); end
         drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, words[i]);
         cycle();
         checks++; if (pc !== 32'(i * 4 + 4)) begin failures++; $display("FAIL seq_pc%0d actual=%h expected=%h", i, pc, 32'(i * 4 + 4)); end
         checks++; if (ifidInstr !== words[i] || ifidPc4 !== 32'(i * 4 + 4) || ifidValid !== 1'b1) begin failures++; $display("FAIL seq_ifid%0d actual=%h/%h/%b expected=%h/%h/1", i, ifidInstr, ifidPc4, ifidValid, words[i], 32'(i * 4 + 4)); end
      end
   endtask

   task automatic test_stall();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hEEEE_0005);
      cycle();
      checks++; if (pc !== 32'h10) begin failures++; $display("FAIL stall_pc actual=%h expected=%h", pc, 32'h10); end
      checks++; if (ifidInstr !== 32'hDDDD_0004 || ifidPc4 !== 32'h10 || ifidValid !== 1'b1) begin failures++; $display("FAIL stall_hold actual=%h/%h/%b expected=dddd0004/00000010/1", ifidInstr, ifidPc4, ifidValid); end
      checks++; if (stallCount !== 32'd1) begin failures++; $display("FAIL stall_count1 actual=%0d expected=1", stallCount); end
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hEEEE_0005);
      cycle();
      checks++; if (pc !== 32'h10 || ifidValid !== 1'b0 || ifidInstr !== 32'h0 || ifidPc4 !== 32'h0) begin failures++; $display("FAIL stall_bubble actual=%h/%b/%h/%h expected=00000010/0/0/0", pc, ifidValid, ifidInstr, ifidPc4); end
      checks++; if (stallCount !== 32'd2) begin failures++; $display("FAIL stall_count2 actual=%0d expected=2", stallCount); end
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hEEEE_0005);
      cycle();
      checks++; if (pc !== 32'h14 || ifidInstr !== 32'hEEEE_0005 || ifidPc4 !== 32'h14 || ifidValid !== 1'b1) begin failures++; $display("FAIL stall_resume actual=%h/%h/%h/%b expected=00000014/eeee0005/00000014/1", pc, ifidInstr, ifidPc4, ifidValid); end
      checks++; if (stallCount !== 32'd2 || flushCount !== 32'd0) begin failures++; $display("FAIL stall_counts actual=%0d/%0d expected=2/0", stallCount, flushCount); end
   endtask

   task automatic test_redirect();
      drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'hFFFF_0006);
      cycle();
      checks++; if (pc !== 32'h40) begin failures++; $display("FAIL redir_pc actual=%h expected=%h", pc, 32'h40); end
      checks++; if (ifidValid !== 1'b0 || ifidInstr !== 32'h0 || ifidPc4 !== 32'h0) begin failures++; $display("FAIL redir_flush actual=%b/%h/%h expected=0/0/0", ifidValid, ifidInstr, ifidPc4); end
      checks++; if (flushCount !== 32'd1) begin failures++; $display("FAIL redir_count actual=%0d expected=1", flushCount); end
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_0007);
      cycle();
      checks++; if (pc !== 32'h44 || ifidInstr !== 32'h1234_0007 || ifidPc4 !== 32'h44 || ifidValid !== 1'b1) begin failures++; $display("FAIL redir_fetch actual=%h/%h/%h/%b expected=00000044/12340007/00000044/1", pc, ifidInstr, ifidPc4, ifidValid); end
   endtask

   task automatic test_redirect_stalled();
      drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h5555_0008);
      cycle();
      checks++; if (pc !== 32'h44 || flushCount !== 32'd1 || stallCount !== 32'd3) begin failures++; $display("FAIL redir_stall actual=%h/%0d/%0d expected=00000044/1/3", pc, flushCount, stallCount); end
      checks++; if (ifidInstr !== 32'h1234_0007 || ifidValid !== 1'b1) begin failures++; $display("FAIL redir_stall_hold actual=%h/%b expected=12340007/1", ifidInstr, ifidValid); end
      drive(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h5555_0008);
      cycle();
      checks++; if (pc !== 32'h80 || flushCount !== 32'd2 || ifidValid !== 1'b0) begin failures++; $display("FAIL redir_retake actual=%h/%0d/%b expected=00000080/2/0", pc, flushCount, ifidValid); end
   endtask

   task automatic test_imem_wait();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h6666_0009);
         cycle();
         checks++; if (pc !== 32'h80 || ifidValid !== 1'b0 || ifidInstr !== 32'h0) begin failures++; $display("FAIL wait%0d actual=%h/%b/%h expected=00000080/0/0", i, pc, ifidValid, ifidInstr); end
      end
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h7777_000A);
      cycle();
      checks++; if (pc !== 32'h84 || ifidInstr !== 32'h7777_000A || ifidPc4 !== 32'h84 || ifidValid !== 1'b1) begin failures++; $display("FAIL wait_done actual=%h/%h/%h/%b expected=00000084/7777000a/00000084/1", pc, ifidInstr, ifidPc4, ifidValid); end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8888_000B);
      cycle();
      checks++; if (pc !== 32'h88 || ifidInstr !== 32'h7777_000A || ifidPc4 !== 32'h84) begin failures++; $display("FAIL advance_hold actual=%h/%h/%h expected=00000088/7777000a/00000084", pc, ifidInstr, ifidPc4); end
   endtask

   task automatic test_wrap();
      drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
      cycle();
      checks++; if (pc !== 32'hFFFF_FFFC || flushCount !== 32'd3) begin failures++; $display("FAIL wrap_setup actual=%h/%0d expected=fffffffc/3", pc, flushCount); end
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h9999_000C);
      cycle();
      checks++; if (pc !== 32'h0 || ifidPc4 !== 32'h0 || ifidInstr !== 32'h9999_000C || ifidValid !== 1'b1) begin failures++; $display("FAIL wrap_adv actual=%h/%h/%h/%b expected=0/0/9999000c/1", pc, ifidPc4, ifidInstr, ifidValid); end
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0043, 1'b1, 32'h0);
      cycle();
      checks++; if (pc !== 32'h40 || flushCount !== 32'd4) begin failures++; $display("FAIL align actual=%h/%0d expected=00000040/4", pc, flushCount); end
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h0);
      cycle();
      checks++; if (stallCount !== 32'd4 || smallStall !== 2'd3) begin failures++; $display("FAIL pre_reset_stall actual=%0d/%0d expected=4/3", stallCount, smallStall); end
      reset = 1'b1;
      cycle();
      checks++; if (pc !== 32'h0 || stallCount !== 32'd0 || flushCount !== 32'd0 || ifidValid !== 1'b0) begin failures++; $display("FAIL mid_reset actual=%h/%0d/%0d/%b expected=0/0/0/0", pc, stallCount, flushCount, ifidValid); end
      reset = 1'b0;
   endtask

   task automatic test_saturation();
      drive(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h0);
      for (int i = 0; i < 5; i++) cycle();
      checks++; if (smallFlush !== 2'd3 || flushCount !== 32'd5) begin failures++; $display("FAIL sat_flush actual=%0d/%0d expected=3/5", smallFlush, flushCount); end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
      for (int i = 0; i < 5; i++) cycle();
      checks++; if (smallStall !== 2'd3 || stallCount !== 32'd5) begin failures++; $display("FAIL sat_stall actual=%0d/%0d expected=3/5", smallStall, stallCount); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_stalled();
      test_imem_wait();
      test_wrap();
      test_reset_mid_stall();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
